// File: rtl/serial_pair_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pair_tx
// Purpose  : Captures two WIDTH-bit operands and streams them out MSB first
//            as bit pairs under a valid/ready handshake, pulsing OP when done.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pair_tx #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_signal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ready,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             OP
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are only loaded in IDLE, so a start request during an
    // operation can never disturb the stream in flight.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (input_signal) begin
                    sh_a_d  = A;
                    sh_b_d  = B;
                    cnt_d   = '0;
                    state_d = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (ready) begin
                    sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
                    sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                    if (last) begin
                        state_d = c_DONE;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        a     = 1'b0;
        b     = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        OP    = 1'b0;
        busy  = (state_q != c_IDLE);
        case (state_q)
            c_SHIFT: begin
                valid = 1'b1;
                a     = sh_a_q[WIDTH-1];
                b     = sh_b_q[WIDTH-1];
                last  = (cnt_q == c_LAST_CNT);
            end
            c_DONE: begin
                OP = 1'b1;
            end
            default: begin
                OP = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_pair_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pair_tx
// Purpose  : Directed self-checking bench for serial_pair_tx (WIDTH 32 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pair_tx;

    logic        clk;
    logic        rst;
    logic        start32, ready32;
    logic [31:0] a_in32, b_in32;
    logic        a32, b32, valid32, last32, busy32, op32;
    logic        start8, ready8;
    logic [7:0]  a_in8, b_in8;
    logic        a8, b8, valid8, last8, busy8, op8;

    int n_checks;
    int n_fail;

    serial_pair_tx #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .input_signal(start32), .A(a_in32), .B(b_in32),
        .ready(ready32), .a(a32), .b(b32), .valid(valid32), .last(last32),
        .busy(busy32), .OP(op32)
    );

    serial_pair_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .input_signal(start8), .A(a_in8), .B(b_in8),
        .ready(ready8), .a(a8), .b(b8), .valid(valid8), .last(last8),
        .busy(busy8), .OP(op8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({a32, b32, valid32, last32, busy32, op32} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset32: got %b expected 000000",
                     {a32, b32, valid32, last32, busy32, op32});
        end
        n_checks++;
        if ({a8, b8, valid8, last8, busy8, op8} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset8: got %b expected 000000",
                     {a8, b8, valid8, last8, busy8, op8});
        end
        rst = 1'b0;
        tick();
    endtask

    // ready held high: pairs after edges 0..31, OP after edge 32, IDLE after 33
    task automatic test_stream32();
        logic [31:0] exp_a, exp_b;
        logic [4:0]  exp_v;
        exp_a = 32'h8000_0001;
        exp_b = 32'h0000_0001;
        a_in32 = exp_a; b_in32 = exp_b; ready32 = 1'b1;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_v = {1'b1, exp_a[31-i], exp_b[31-i], (i == 31), 1'b1};
            n_checks++;
            if ({valid32, a32, b32, last32, busy32} !== exp_v) begin
                n_fail++;
                $display("FAIL stream32 pair %0d: got v/a/b/l/busy=%b expected %b",
                         i, {valid32, a32, b32, last32, busy32}, exp_v);
            end
            tick();
        end
        n_checks++;
        if ({op32, valid32, busy32} !== 3'b101) begin
            n_fail++;
            $display("FAIL stream32 done: got op/valid/busy=%b expected 101", {op32, valid32, busy32});
        end
        tick();
        n_checks++;
        if ({op32, valid32, busy32} !== 3'b000) begin
            n_fail++;
            $display("FAIL stream32 idle: got op/valid/busy=%b expected 000", {op32, valid32, busy32});
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_a, exp_b;
        logic [3:0]  exp_v;
        int k, cyc;
        exp_a = 32'h8000_0001;
        exp_b = 32'h0000_0001;
        a_in32 = exp_a; b_in32 = exp_b; ready32 = 1'b1;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        k = 0; cyc = 0;
        while (k < 32 && cyc < 200) begin
            ready32 = (cyc % 2 == 0);
            exp_v = {1'b1, exp_a[31-k], exp_b[31-k], (k == 31)};
            n_checks++;
            if ({valid32, a32, b32, last32} !== exp_v || op32 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall pair %0d cyc %0d: got v/a/b/l=%b op=%b expected %b op=0",
                         k, cyc, {valid32, a32, b32, last32}, op32, exp_v);
            end
            tick();
            if (ready32) k++;
            cyc++;
        end
        n_checks++;
        if (k != 32 || op32 !== 1'b1 || valid32 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall done: got transfers=%0d op=%b valid=%b expected 32 1 0",
                     k, op32, valid32);
        end
        ready32 = 1'b1;
        tick();
    endtask

    task automatic test_ignore_restart();
        a_in32 = 32'hFFFF_FFFF; b_in32 = 32'h0; ready32 = 1'b1;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                start32 = 1'b1; a_in32 = 32'h0; b_in32 = 32'hFFFF_FFFF;
            end
            if (i == 6) start32 = 1'b0;
            n_checks++;
            if ({valid32, a32, b32} !== 3'b110) begin
                n_fail++;
                $display("FAIL ignore_restart pair %0d: got v/a/b=%b expected 110",
                         i, {valid32, a32, b32});
            end
            tick();
        end
        n_checks++;
        if (op32 !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_restart op: got %b expected 1", op32);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_a, exp_b;
        logic [2:0]  exp_v;
        a_in32 = 32'h8000_0001; b_in32 = 32'h0000_0001; ready32 = 1'b1;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({valid32, busy32, op32, last32} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid/busy/op/last=%b expected 0000",
                     {valid32, busy32, op32, last32});
        end
        tick();
        n_checks++;
        if ({valid32, busy32, op32} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_mid after: got valid/busy/op=%b expected 000", {valid32, busy32, op32});
        end
        exp_a = 32'h1234_5678;
        exp_b = 32'hEDCB_A987;
        a_in32 = exp_a; b_in32 = exp_b;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_v = {1'b1, exp_a[31-i], exp_b[31-i]};
            n_checks++;
            if ({valid32, a32, b32} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid fresh pair %0d: got v/a/b=%b expected %b",
                         i, {valid32, a32, b32}, exp_v);
            end
            tick();
        end
        n_checks++;
        if (op32 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid fresh op: got %b expected 1", op32);
        end
        tick();
    endtask

    task automatic test_width8();
        logic [7:0] exp_a, exp_b;
        logic [3:0] exp_v;
        exp_a = 8'b1010_0101;
        exp_b = 8'b0101_1010;
        a_in8 = 8'hA5; b_in8 = 8'h5A; ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_v = {1'b1, exp_a[7-i], exp_b[7-i], (i == 7)};
            n_checks++;
            if ({valid8, a8, b8, last8} !== exp_v) begin
                n_fail++;
                $display("FAIL width8 pair %0d: got v/a/b/l=%b expected %b",
                         i, {valid8, a8, b8, last8}, exp_v);
            end
            tick();
        end
        n_checks++;
        if ({op8, valid8} !== 2'b10) begin
            n_fail++;
            $display("FAIL width8 done: got op/valid=%b expected 10", {op8, valid8});
        end
        tick();
        n_checks++;
        if ({op8, busy8} !== 2'b00) begin
            n_fail++;
            $display("FAIL width8 idle: got op/busy=%b expected 00", {op8, busy8});
        end
    endtask

    // Start held high: each operation followed by exactly one DONE and one IDLE cycle
    task automatic test_back_to_back();
        logic [31:0] exp_a;
        exp_a = 32'hC3A5_0F96;
        a_in32 = exp_a; b_in32 = ~exp_a; ready32 = 1'b1;
        start32 = 1'b1;
        tick();
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if ({valid32, a32, b32, op32} !== {1'b1, exp_a[31-i], ~exp_a[31-i], 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b op %0d pair %0d: got v/a/b/op=%b expected %b",
                             op, i, {valid32, a32, b32, op32},
                             {1'b1, exp_a[31-i], ~exp_a[31-i], 1'b0});
                end
                tick();
            end
            n_checks++;
            if ({op32, busy32, valid32} !== 3'b110) begin
                n_fail++;
                $display("FAIL b2b op %0d done: got op/busy/valid=%b expected 110",
                         op, {op32, busy32, valid32});
            end
            tick();
            n_checks++;
            if ({op32, busy32, valid32} !== 3'b000) begin
                n_fail++;
                $display("FAIL b2b op %0d idle: got op/busy/valid=%b expected 000",
                         op, {op32, busy32, valid32});
            end
            tick();
        end
        start32 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        start32 = 1'b0; ready32 = 1'b0; a_in32 = '0; b_in32 = '0;
        start8  = 1'b0; ready8  = 1'b0; a_in8  = '0; b_in8  = '0;
        test_reset();
        test_stream32();
        test_stall();
        test_ignore_restart();
        test_reset_mid();
        test_width8();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
